// File: rtl/data_req_issue_pkg.sv
// Shared encodings, widths and store-formatting helpers for the data request initiator.
package data_req_issue_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned CNT_W  = 2;

    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    // Registered bus request payload, held stable while data_req is high
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // Size 3 is treated as word for alignment and formatting
    function automatic logic addr_misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            SZ_W:    mis = (lo != 2'b00);
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [STRB_W-1:0] fmt_wstrb(input logic wr, input logic [SIZE_W-1:0] size,
                                                     input logic [1:0] lo);
        logic [STRB_W-1:0] strb;
        case (size)
            SZ_B:    strb = 4'b0001 << lo;
            SZ_H:    strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return wr ? strb : '0;
    endfunction

    function automatic logic [DATA_W-1:0] fmt_wdata(input logic [SIZE_W-1:0] size, input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] d;
        case (size)
            SZ_B:    d = {4{wdata[7:0]}};
            SZ_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_req_issue_req_tag_fifo.sv
// req_tag_fifo: two-entry FIFO holding the store/load flag of each in-flight request.
module data_req_issue_req_tag_fifo (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_push_data,
    input  logic i_pop,
    output logic o_head_c
);

    logic [1:0] r_mem;
    logic       r_wr_ptr;
    logic       r_rd_ptr;

    assign o_head_c = r_mem[r_rd_ptr];

    // Storage and pointers; push and pop may happen in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/data_req_issue.sv
// Data-memory request initiator: issues loads/stores on the SRAM-like bus,
// tracks up to two in-flight requests and drops responses killed by a flush.
module data_req_issue
    import data_req_issue_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_wr,
    input  logic [SIZE_W-1:0] op_size,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              op_ale,
    output logic              data_req,
    output logic              data_wr,
    output logic [SIZE_W-1:0] data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [STRB_W-1:0] data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_wr,
    output logic [DATA_W-1:0] resp_rdata
);

    state_e            r_state;
    state_e            w_state_next;
    bus_req_t          r_req;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard_cnt;
    logic [CNT_W-1:0]  w_outstanding_next;
    logic [CNT_W-1:0]  w_discard_next;
    logic              r_resp_valid;
    logic              r_resp_wr;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              w_ale;
    logic              w_has_room;
    logic              w_op_hs;
    logic              w_addr_hs;
    logic              w_drop;
    logic              w_tag_head;

    // Alignment check is independent of state so the execute stage sees it immediately
    assign w_ale      = op_valid & addr_misaligned(op_size, op_addr[1:0]);
    // A buffered response occupies a slot so the single response register is never overrun
    assign w_has_room = (3'(r_outstanding) + 3'(r_resp_valid)) < 3'(MAX_OUTSTANDING);
    assign op_ready   = (r_state == S_IDLE) & ~flush & ~w_ale & w_has_room;
    assign w_op_hs    = op_valid & op_ready;
    assign w_addr_hs  = (r_state == S_REQ) & data_addr_ok;
    assign w_drop     = data_data_ok & (r_discard_cnt != '0);
    assign op_ale     = w_ale;

    assign data_req   = (r_state == S_REQ);
    assign data_wr    = r_req.wr;
    assign data_size  = r_req.size;
    assign data_addr  = r_req.addr;
    assign data_wstrb = r_req.wstrb;
    assign data_wdata = r_req.wdata;

    assign resp_valid = r_resp_valid;
    assign resp_wr    = r_resp_wr;
    assign resp_rdata = r_resp_rdata;

    data_req_issue_req_tag_fifo u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_addr_hs),
        .i_push_data (r_req.wr),
        .i_pop       (data_data_ok),
        .o_head_c    (w_tag_head)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: request stays up until the bus accepts it, flush or not
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_op_hs)      w_state_next = S_REQ;
            S_REQ:   if (data_addr_ok) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next in-flight and discard counts; a flush kills everything in flight plus a pending request
    always_comb begin
        w_outstanding_next = r_outstanding;
        w_discard_next     = r_discard_cnt;
        if (w_addr_hs) begin
            w_outstanding_next = w_outstanding_next + CNT_W'(1);
        end
        if (data_data_ok) begin
            w_outstanding_next = w_outstanding_next - CNT_W'(1);
        end
        if (w_drop) begin
            w_discard_next = r_discard_cnt - CNT_W'(1);
        end
        if (flush) begin
            w_discard_next = w_outstanding_next + CNT_W'((r_state == S_REQ) & ~data_addr_ok);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
            r_discard_cnt <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_discard_cnt <= w_discard_next;
        end
    end

    // Latch the formatted request on the execute-stage handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_op_hs) begin
            r_req.wr    <= op_wr;
            r_req.size  <= op_size;
            r_req.addr  <= op_addr;
            r_req.wstrb <= fmt_wstrb(op_wr, op_size, op_addr[1:0]);
            r_req.wdata <= fmt_wdata(op_size, op_wdata);
        end
    end

    // Response buffer: flush wins, then a live response, then consumption
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_wr    <= 1'b0;
            r_resp_rdata <= '0;
        end else if (flush) begin
            r_resp_valid <= 1'b0;
        end else if (data_data_ok && !w_drop) begin
            r_resp_valid <= 1'b1;
            r_resp_wr    <= w_tag_head;
            r_resp_rdata <= data_rdata;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    // A response with nothing in flight means the bus broke the protocol
    assert property (@(posedge clk) disable iff (reset) data_data_ok |-> (r_outstanding != '0));

endmodule
